mips_run_monitor: RTL

Synthesizable end-of-program monitor and data-memory dump engine for the pipelined MIPS core. It watches the fetch PC, detects arrival at a configurable end address or expiry of a cycle budget, and then reads a configurable window of data memory through a dedicated read port. Each word is streamed out over a valid/ready channel. It replaces simulation-only PC watching and memory peeking, so regression dumps work on FPGA and in gate-level runs.

---
 rtl/mips_run_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_run_monitor.sv
// End-of-program monitor: watches the fetch PC for END_PC or a cycle budget, then dumps a data-memory window.
// Latency: trigger to first mem_rd 1 cycle, mem_rd to dump_valid 2 cycles, 3 cycles per word with no stalls.
// Backpressure: dump_data/dump_index hold in SEND until dump_ready; run_en=0 aborts and withdraws dump_valid.
module mips_run_monitor #(
  parameter int               PC_W       = 32,
  parameter int               DATA_W     = 32,
  parameter int               ADDR_W     = 10,
  parameter logic [PC_W-1:0]  END_PC     = 32'hA4,
  parameter int               DUMP_BASE  = 50,
  parameter int               DUMP_COUNT = 21,
  parameter int               TIMEOUT    = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic [PC_W-1:0]   pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_COUNT - 1);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              last_word;
  logic              end_hit;
  logic              budget_hit;

  assign last_word  = (idx == LAST_IDX);
  assign end_hit    = (pc == END_PC);
  assign budget_hit = (cycles == TO_LAST);
  assign dump_index = idx;

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; dropping run_en aborts any active state.
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_en) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (!run_en)                     state_nxt = S_IDLE;
        else if (end_hit || budget_hit)  state_nxt = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = BASE_A + idx;  // wraps modulo 2^ADDR_W by truncation
        state_nxt = run_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        busy      = 1'b1;
        state_nxt = run_en ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (!run_en)         state_nxt = S_IDLE;
        else if (dump_ready) state_nxt = last_word ? S_DONE : S_READ;
      end
      S_DONE: begin
        done = 1'b1;
        if (!run_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run counter, trigger cause, word index and captured read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles    <= '0;
      timeout   <= 1'b0;
      idx       <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cycles  <= '0;
          timeout <= 1'b0;
          idx     <= '0;
        end
        S_RUN: begin
          // END_PC wins over the budget; in both trigger cases the count freezes.
          if (run_en && !end_hit) begin
            if (budget_hit)           timeout <= 1'b1;
            else if (cycles != '1)    cycles  <= cycles + 32'd1;
          end
        end
        S_WAIT: begin
          dump_data <= mem_rdata;
        end
        S_SEND: begin
          if (run_en && dump_ready && !last_word) idx <= idx + 1'b1;
        end
        default: ;
      endcase
      // Leaving for IDLE (abort or end of DONE) clears the run record.
      if (state != S_IDLE && state_nxt == S_IDLE) begin
        cycles  <= '0;
        timeout <= 1'b0;
        idx     <= '0;
      end
    end
  end

endmodule
